// File: rtl/mat_mul_stream.sv
// mat_mul_stream: streaming matrix multiplier S = A(ROWS x INNER) * B(INNER x COLS).
// Operands arrive one element per handshake: A row-major, then B row-major.
// Results leave one element per handshake in row-major order. A single
// INNER-wide dot-product engine is reused for every output element.
// Build option: define MAT_MUL_SIGNED_EN for two's-complement operands
// (unsigned when undefined).
//
// state  | meaning
// S_LOAD | accepting operand elements into A/B storage
// S_RUN  | issuing S[r][c] into the output register, honouring backpressure
module mat_mul_stream #(
  parameter int ROWS  = 4,
  parameter int INNER = 4,
  parameter int COLS  = 2,
  parameter int DW    = 4,
  parameter int OW    = 2*DW + $clog2(INNER)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [OW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_busy
);

  localparam int NA = ROWS * INNER;
  localparam int NB = INNER * COLS;
  localparam int NT = NA + NB;
  localparam int PW = 2 * DW;
  localparam int LW = (NT > 1)   ? $clog2(NT)   : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_a_mem [NA];
  logic [DW-1:0] r_b_mem [NB];

  logic [LW-1:0] r_ld_idx;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  logic          w_in_ready_st;
  logic          w_in_hs;
  logic          w_ld_last;
  logic          w_out_hs;
  logic          w_load;
  logic          w_last_rc;

  logic [DW-1:0] w_a_sel [INNER];
  logic [DW-1:0] w_b_sel [INNER];
  logic [PW-1:0] w_prod  [INNER];
  logic [OW-1:0] w_dot;

  // in_ready is gated by reset so it stays low while rst_n is asserted
  assign o_in_ready = w_in_ready_st & i_rst_n;
  assign w_in_hs    = i_in_valid & o_in_ready;
  assign w_ld_last  = (r_ld_idx == LW'(NT - 1));
  assign w_out_hs   = o_out_valid & i_out_ready;
  assign w_last_rc  = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));

  // Output register may take a new element when empty or being drained;
  // a registered out_last means every element has already been issued.
  assign w_load = (r_state == S_RUN) && !o_out_last && (!o_out_valid || i_out_ready);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_in_ready_st = 1'b0;
    o_busy        = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready_st = 1'b1;
        if (i_in_valid && w_ld_last) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_out_hs && o_out_last) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // Load index: advances per accepted operand, wraps to 0 after the last one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_idx <= '0;
    end else if (w_in_hs) begin
      if (w_ld_last) begin
        r_ld_idx <= '0;
      end else begin
        r_ld_idx <= r_ld_idx + 1'b1;
      end
    end
  end

  // Operand storage; contents after reset are don't-care so no reset here
  always_ff @(posedge i_clk) begin
    if (w_in_hs) begin
      for (int i = 0; i < NA; i++) begin
        if (r_ld_idx == LW'(i)) begin
          r_a_mem[i] <= i_in_data;
        end
      end
      for (int j = 0; j < NB; j++) begin
        if (r_ld_idx == LW'(NA + j)) begin
          r_b_mem[j] <= i_in_data;
        end
      end
    end
  end

  // Select row r of A and column c of B for the dot-product engine
  always_comb begin
    for (int k = 0; k < INNER; k++) begin
      w_a_sel[k] = '0;
      w_b_sel[k] = '0;
    end
    for (int k = 0; k < INNER; k++) begin
      for (int i = 0; i < ROWS; i++) begin
        if (r_row == RW'(i)) begin
          w_a_sel[k] = r_a_mem[i*INNER + k];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        if (r_col == CW'(j)) begin
          w_b_sel[k] = r_b_mem[k*COLS + j];
        end
      end
    end
  end

  // Dot product: INNER multipliers feeding an OW-bit sum (wide enough for no overflow)
  always_comb begin
    w_dot = '0;
    for (int k = 0; k < INNER; k++) begin
      w_prod[k] = '0;
    end
    for (int k = 0; k < INNER; k++) begin
`ifdef MAT_MUL_SIGNED_EN
      w_prod[k] = PW'($signed(PW'($signed(w_a_sel[k]))) * $signed(PW'($signed(w_b_sel[k]))));
      w_dot     = w_dot + OW'($signed(w_prod[k]));
`else
      w_prod[k] = PW'(w_a_sel[k]) * PW'(w_b_sel[k]);
      w_dot     = w_dot + OW'(w_prod[k]);
`endif
    end
  end

  // Output register and r/c walk; everything holds while stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_last  <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
    end else if (w_in_hs && w_ld_last) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_load) begin
      o_out_valid <= 1'b1;
      o_out_data  <= w_dot;
      o_out_last  <= w_last_rc;
      if (w_last_rc) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == CW'(COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (w_out_hs) begin
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_mul_stream.sv
// Bench for mat_mul_stream: directed and random matrices checked against a
// plain-arithmetic matrix-product model.
module tb_mat_mul_stream;
  localparam int ROWS = 4, INNER = 4, COLS = 2, DW = 4, OW = 10;
  localparam int NA = ROWS * INNER, NT = NA + INNER * COLS, NR = ROWS * COLS;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [OW-1:0] o_out_data;
  logic          o_out_last;
  logic          o_busy;

  always #5 clk = ~clk;

  mat_mul_stream #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS), .DW(DW), .OW(OW)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last), .o_busy(o_busy));

  int n_pass = 0;
  int n_total = 0;
  int a_m [ROWS][INNER];
  int b_m [INNER][COLS];
  logic [OW-1:0] exp_s [NR];
  logic [OW-1:0] res [NR];
  int n_res;
  int first_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int sval(input int x);
`ifdef MAT_MUL_SIGNED_EN
    return (x >= 8) ? x - 16 : x;
`else
    return x;
`endif
  endfunction

  function automatic void model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int s = 0;
        for (int k = 0; k < INNER; k++) s += sval(a_m[r][k]) * sval(b_m[k][c]);
        exp_s[r*COLS + c] = OW'(s);
      end
  endfunction

  function automatic int elem(input int idx);
    if (idx < NA) return a_m[idx / INNER][idx % INNER];
    return b_m[(idx - NA) / COLS][(idx - NA) % COLS];
  endfunction

  function automatic void randomize_mats();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < INNER; k++) a_m[r][k] = $urandom_range(0, 15);
    for (int k = 0; k < INNER; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = $urandom_range(0, 15);
  endfunction

  task automatic load_mat(input int gap_pct, input bit hold_valid);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < NT && cyc < 500) begin
      i_in_valid = ($urandom_range(0, 99) >= gap_pct);
      i_in_data  = DW'(elem(idx));
      hs = i_in_valid && o_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    check("load_done", idx, NT);
    i_in_valid = hold_valid;
    i_in_data  = DW'($urandom);
    check("run_no_early_valid", o_out_valid, 0);
    check("run_busy", o_busy, 1);
    check("run_in_ready", o_in_ready, 0);
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready
  task automatic collect(input int mode, input int nres, input bit junk);
    int cyc = 0;
    bit stall = 0;
    bit bad_ready = 0;
    logic [OW-1:0] pd;
    logic pl;
    n_res = 0;
    first_lat = -1;
    while (n_res < nres && cyc < 300) begin
      if (stall) begin
        check("stall_valid", o_out_valid, 1);
        check("stall_data", o_out_data, pd);
        check("stall_last", o_out_last, pl);
      end
      if (o_in_ready) bad_ready = 1;
      if (o_out_valid && first_lat < 0) first_lat = cyc;
      case (mode)
        0: i_out_ready = 1'b1;
        1: i_out_ready = (cyc % 3 == 0);
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        i_in_valid = !(o_out_valid && o_out_last && i_out_ready);
        i_in_data  = DW'($urandom);
      end
      stall = o_out_valid && !i_out_ready;
      pd = o_out_data;
      pl = o_out_last;
      if (o_out_valid && i_out_ready) begin
        res[n_res] = o_out_data;
        check("data", o_out_data, exp_s[n_res]);
        check("last", o_out_last, (n_res == NR - 1));
        n_res++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_in_valid = 1'b0;
    check("collect_count", n_res, nres);
    check("run_in_ready_low", bad_ready, 0);
    check("first_latency", first_lat, 1);
    if (nres == NR) begin
      check("done_valid_low", o_out_valid, 0);
      check("done_in_ready", o_in_ready, 1);
      check("done_busy", o_busy, 0);
    end
  endtask

  function automatic void identity_mats();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < INNER; k++) a_m[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < INNER; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = k*COLS + c + 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
    #12;
    check("rst_in_ready", o_in_ready, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data", o_out_data, 0);
    check("rst_out_last", o_out_last, 0);
    check("rst_busy", o_busy, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    #1;
    check("rel_in_ready", o_in_ready, 1);
    check("rel_busy", o_busy, 0);

    // identity A, B = 1..8, no backpressure
    identity_mats(); model();
    load_mat(0, 0);
    collect(0, NR, 0);
`ifndef MAT_MUL_SIGNED_EN
    for (int i = 0; i < NR; i++) check("ident_val", res[i], i + 1);
`endif

    // all operands 15
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < INNER; k++) a_m[r][k] = 15;
    for (int k = 0; k < INNER; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = 15;
    model();
    load_mat(30, 0);
    collect(0, NR, 0);
`ifndef MAT_MUL_SIGNED_EN
    for (int i = 0; i < NR; i++) check("max_val", res[i], 900);
`endif

    // identity again with ready pattern 1,0,0
    identity_mats(); model();
    load_mat(0, 0);
    collect(1, NR, 0);
`ifndef MAT_MUL_SIGNED_EN
    for (int i = 0; i < NR; i++) check("bp_val", res[i], i + 1);
`endif

    // reset after 4 accepted results, then a fresh full matrix
    randomize_mats(); model();
    load_mat(0, 0);
    collect(0, 4, 0);
    i_out_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_in_ready", o_in_ready, 0);
    check("midrst_out_valid", o_out_valid, 0);
    check("midrst_busy", o_busy, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    #1;
    check("postrst_out_valid", o_out_valid, 0);
    check("postrst_in_ready", o_in_ready, 1);
    randomize_mats(); model();
    load_mat(40, 0);
    collect(2, NR, 0);

    // back-to-back: random matrix with in_valid held during run, then A=1 B=2
    randomize_mats(); model();
    load_mat(20, 1);
    collect(2, NR, 1);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < INNER; k++) a_m[r][k] = 1;
    for (int k = 0; k < INNER; k++) for (int c = 0; c < COLS; c++) b_m[k][c] = 2;
    model();
    load_mat(0, 0);
    collect(0, NR, 0);
    for (int i = 0; i < NR; i++) check("b2b_val", res[i], 8);

`ifdef MAT_MUL_SIGNED_EN
    randomize_mats();
    for (int k = 0; k < INNER; k++) begin
      a_m[0][k] = 8;
      b_m[k][0] = 8;
      b_m[k][1] = 7;
    end
    model();
    load_mat(0, 0);
    collect(0, NR, 0);
    check("signed_s00", res[0], 256);
    check("signed_s01", res[1], 10'h320);
`endif

    // random matrices with random gaps and backpressure
    for (int t = 0; t < 3; t++) begin
      randomize_mats(); model();
      load_mat(50, 0);
      collect(2, NR, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mat_mul_stream.md
Name: mat_mul_stream

Overview:
- Parametrised, sequential successor to the fixed 4x4-by-4x2 combinational matrix multiplier.
- Computes S = A(ROWS x INNER) * B(INNER x COLS).
- Operands arrive over a serial valid/ready element stream. Results leave one element per cycle over a valid/ready stream with backpressure.
- Sits between the operand buffer and the result sink in the SO_ML datapath. One INNER-wide dot-product engine is reused for every output element.

Parameters:
- ROWS, 4, rows of A and of S
- INNER, 4, columns of A = rows of B
- COLS, 2, columns of B and of S
- DW, 4, operand element width
- OW, 2*DW+$clog2(INNER), result element width (default 10)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand element valid
- in_ready  out  1  block accepts operand element
- in_data  in  DW  operand element: A row-major first, then B row-major
- out_valid  out  1  result element valid
- out_ready  in  1  sink accepts result element
- out_data  out  OW  result element S[r][c], row-major order
- out_last  out  1  high with the final element S[ROWS-1][COLS-1]
- busy  out  1  high in S_RUN

Behaviour:
- Reset (async, rst_n=0):
  - State = S_LOAD; all counters = 0.
  - in_ready=0 while reset is asserted, then 1 in S_LOAD.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - Operand storage contents are don't-care.
- Registers: A_mem holds ROWS*INNER elements; B_mem holds INNER*COLS elements.
- S_LOAD:
  - in_ready=1. Each in_valid&in_ready writes in_data at load index ld_idx, then ld_idx++.
  - Indices 0..ROWS*INNER-1 go to A; the rest go to B.
  - When the element at index ROWS*INNER+INNER*COLS-1 is accepted, go to S_RUN and clear r=0, c=0. No output in the same cycle.
- S_RUN:
  - in_ready=0; busy=1.
  - The engine forms sum over k of A[r][k]*B[k][c] combinationally (INNER multipliers plus an adder tree). The result is registered into out_data.
  - Load rule: the output register loads when out_valid==0 or (out_valid&out_ready).
  - On each load: out_valid=1, out_data=dot(r,c), out_last=(r==ROWS-1 && c==COLS-1). Then c++; on wrap c=0 and r++.
  - First out_valid rises exactly 1 cycle after the last operand handshake.
  - With out_ready held at 1, results stream 1 per cycle: ROWS*COLS cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and r/c hold stable.
- Completion: when the handshake on the out_last element occurs, go to S_LOAD next cycle.
  - out_valid=0 and in_ready=1 in that next cycle.
  - ld_idx=0; operand memories are overwritten by the next load.
- Arithmetic: unsigned by default. Products are 2*DW bits and are summed at OW bits, so there is no overflow for any input (15*15*4 = 900 < 1024).
- in_valid is ignored outside S_LOAD.
- out_ready is ignored while out_valid=0.
- Reset mid-load or mid-run aborts the matrix. No partial result is emitted after reset release.
- Degenerate parameter values (any parameter = 0) are illegal; behaviour for them is unspecified.

Optional Feature:
- Macro: MAT_MUL_SIGNED_EN.
- Defined: operands are two's complement. Each operand is sign-extended, the product is a signed 2*DW value, and the sum is signed over OW bits.
  - Example: A row = [-8,-8,-8,-8], B column = [-8,-8,-8,-8] gives 256.
  - Example: A row = [-8,-8,-8,-8], B column = [7,7,7,7] gives -224 (10'h320).
- Undefined: all operands are unsigned, as described in Behaviour.

Test Plan:
- Identity A (ROWS=INNER=4), B = [[1,2],[3,4],[5,6],[7,8]], out_ready=1 -> out_data 1,2,3,4,5,6,7,8 on consecutive cycles; out_last only on the 8th; first out_valid 1 cycle after the 24th input handshake.
- All operands 15 -> eight results of 900 (10'h384); no truncation.
- Same data as test 1, out_ready toggled 1,0,0,1,... -> each element held stable while stalled; order and values unchanged; exactly 8 handshakes; in_ready=0 throughout.
- rst_n pulsed low after 4 results accepted -> out_valid=0, in_ready=1 immediately after release; a new 24-element load produces the correct full result set.
- Two back-to-back matrices (second: A all 1, B all 2) -> the second set is all 8s; in_ready rises the cycle after the out_last handshake; in_valid held high during S_RUN is ignored.
- With MAT_MUL_SIGNED_EN defined: A row 0 all -8, B col 0 all -8, B col 1 all 7 -> S[0][0]=256, S[0][1]=-224.
